nibble_serial_addsub_arbiter: RTL

Sequencer that performs WIDTH-bit two's-complement add/subtract one 4-bit nibble per clock on an internal 4-bit add/sub slice. The slice computes a + (b ^ {4{sub}}) + carry. Two requesters share the slice through a round-robin arbiter. It sits between the dataflow arithmetic slices and any client blocks that need wide add/sub without a full-width carry chain.

---
 rtl/nibble_serial_addsub_arbiter_if.sv | 33 +++
 rtl/nibble_serial_addsub_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_addsub_arbiter_if.sv
// Bus between two add/sub requesters and the nibble-serial add/sub sequencer.
// The requester side drives requests and operands; the sequencer side returns
// grants, status and the registered result.
interface nibble_serial_addsub_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             req0;
    logic             req1;
    logic             sub0;
    logic             sub1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             ovf;

    modport master (
        output req0, req1, sub0, sub1, a0, b0, a1, b1,
        input  gnt0, gnt1, busy, done, done_id, result, c_out, ovf
    );

    modport slave (
        input  req0, req1, sub0, sub1, a0, b0, a1, b1,
        output gnt0, gnt1, busy, done, done_id, result, c_out, ovf
    );
endinterface

// File: rtl/nibble_serial_addsub_arbiter.sv
// Nibble-serial two's-complement add/subtract shared by two requesters.
// A round-robin arbiter picks one requester in IDLE, its operands are
// captured, then one 4-bit slice processes a nibble per clock (LSB first).
// Result, carry-out and signed overflow are registered on entry to DONE and
// held until the next operation completes.
module nibble_serial_addsub_arbiter #(
    parameter int WIDTH = 16
) (
    input logic                          clk_i,
    input logic                          rst_i,
    nibble_serial_addsub_arbiter_if.slave bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // 4-bit slice: a + (b ^ {4{sub}}) + cin.
    // Returns {carry into bit 3, carry out of bit 3, sum nibble}; the carry
    // into bit 3 is needed for signed overflow on the most significant nibble.
    function automatic logic [5:0] slice_add(input logic [3:0] a_nib,
                                             input logic [3:0] b_nib,
                                             input logic       sub,
                                             input logic       cin);
        logic [3:0] bx;
        logic [3:0] low;
        logic [1:0] top;
        bx  = b_nib ^ {4{sub}};
        low = {1'b0, a_nib[2:0]} + {1'b0, bx[2:0]} + {3'b000, cin};
        top = {1'b0, a_nib[3]} + {1'b0, bx[3]} + {1'b0, low[3]};
        return {low[3], top[1], top[0], low[2:0]};
    endfunction

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              sub_q, sub_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              done_id_q, done_id_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              c_out_q, c_out_d;
    logic              ovf_q, ovf_d;

    logic [5:0]        slice_s;
    logic              winner_s;

    // Current nibble of the captured operands through the shared slice.
    assign slice_s = slice_add(a_q[{idx_q, 2'b00} +: 4], b_q[{idx_q, 2'b00} +: 4],
                               sub_q, carry_q);

    // Round-robin winner: a lone request wins, a tie goes to the one not granted last.
    assign winner_s = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sub_d     = sub_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        last_d    = last_q;
        owner_d   = owner_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        result_d  = result_q;
        c_out_d   = c_out_q;
        ovf_d     = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    if (winner_s) begin
                        a_d    = bus.a1;
                        b_d    = bus.b1;
                        sub_d  = bus.sub1;
                        gnt1_d = 1'b1;
                    end else begin
                        a_d    = bus.a0;
                        b_d    = bus.b0;
                        sub_d  = bus.sub0;
                        gnt0_d = 1'b1;
                    end
                    carry_d = winner_s ? bus.sub1 : bus.sub0;
                    idx_d   = '0;
                    owner_d = winner_s;
                    last_d  = winner_s;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d[{idx_q, 2'b00} +: 4] = slice_s[3:0];
                carry_d = slice_s[4];
                if (idx_q == IDXW'(NIB - 1)) begin
                    result_d  = acc_d;
                    c_out_d   = slice_s[4];
                    ovf_d     = slice_s[5] ^ slice_s[4];
                    done_id_d = owner_q;
                    done_d    = 1'b1;
                    idx_d     = '0;
                    state_d   = DONE;
                end else begin
                    idx_d   = idx_q + IDXW'(1);
                    state_d = RUN;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            acc_q     <= '0;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            result_q  <= '0;
            c_out_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sub_q     <= sub_d;
            carry_q   <= carry_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            result_q  <= result_d;
            c_out_q   <= c_out_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.result  = result_q;
    assign bus.c_out   = c_out_q;
    assign bus.ovf     = ovf_q;
endmodule
